image_mem_port: RTL

Responder side of the image-memory request interface issued by the control unit. Accepts single-pixel read requests against the raw-image memory and write requests against the processed-image memory. Owns the two auto-incrementing pixel pointers, with wrap at end of frame. Sits between the control unit/register file and the two on-chip image memories, and returns read data via a valid pulse.

---
 rtl/img_pkg.sv | 26 ++
 rtl/image_mem_port_if.sv | 31 +++
 rtl/wrap_counter.sv | 44 ++++
 rtl/image_mem_port.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the image-memory responder.
//   - Frame geometry and bus widths used as parameter defaults.
//   - Read-channel state enum and the debug snapshot struct exported by the top.
package img_pkg;

    localparam int IMG_PIXELS   = 152100; // 390 x 390 pixels per frame
    localparam int ADDR_W       = 18;     // 2^18 >= IMG_PIXELS
    localparam int PIX_W        = 8;
    localparam int DATA_W       = 32;
    localparam int READ_LATENCY = 1;      // raw memory latency, 1..3 cycles

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } rd_state_e;

    // Observation snapshot of the read channel and both pointers.
    typedef struct packed {
        rd_state_e  rd_state;
        logic [1:0] lat_cnt;
        logic       rd_ptr_at_last;
        logic       wr_ptr_at_last;
    } dbg_t;

endpackage

// File: rtl/image_mem_port_if.sv
// Request bus between the control unit (master) and image_mem_port (slave).
//   rd_req/rd_ready : read request, taken in a cycle where both are 1
//   rd_valid/rd_data: one-cycle completion pulse; rd_data holds until the next pulse
//   wr_req/wr_data  : write request, always taken (no back-pressure)
//   ptr_clr         : clear both pixel pointers
//
// Handshake: a read transfer happens on a rising edge where rd_req and rd_ready
// are both high; rd_req seen while rd_ready is low is dropped, not queued.
// rd_ready is high again in the cycle rd_valid pulses, so a new request can be
// made there. Writes have no ready: every cycle with wr_req=1 is one write.
interface image_mem_port_if #(
    parameter int DATA_W = img_pkg::DATA_W
);
    logic              rd_req;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              ptr_clr;

    modport master (
        output rd_req, wr_req, wr_data, ptr_clr,
        input  rd_ready, rd_valid, rd_data
    );

    modport slave (
        input  rd_req, wr_req, wr_data, ptr_clr,
        output rd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/wrap_counter.sv
// Pixel pointer that wraps at the end of a frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the pointer back to 0 (wins over inc)
//   inc        : advance by one; with clr the advance starts from 0, giving 1
//   value      : current pointer
//   at_last    : value is the last pixel of the frame
module wrap_counter #(
    parameter int IMG_PIXELS = img_pkg::IMG_PIXELS,
    parameter int ADDR_W     = img_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] value,
    output logic              at_last
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_PIXELS - 1);

    logic [ADDR_W-1:0] value_q;
    logic [ADDR_W-1:0] value_d;
    logic [ADDR_W-1:0] base;

    always_comb begin
        // A clear in the same cycle as an increment means the access used
        // address 0, so the increment is applied on top of the cleared value.
        base    = clr ? '0 : value_q;
        value_d = base;
        if (inc) begin
            value_d = (base == LAST) ? '0 : base + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign at_last = (value_q == LAST);
endmodule

// File: rtl/image_mem_port.sv
// Responder for the control unit's image-memory requests.
//   clk, rst_n           : clock, asynchronous active-low reset
//   bus (slave)          : read/write request bus, see image_mem_port_if
//   raw_en/raw_addr/raw_q: raw-image memory read port (READ_LATENCY cycles)
//   proc_we/proc_addr/proc_d : processed-image memory write port
//   rd_ptr, wr_ptr       : current pixel pointers
//   frame_done           : pulse with the write of the last pixel of a frame
//   dbg                  : read FSM state and counter snapshot
// Reads go IDLE -> ISSUE -> WAIT (READ_LATENCY cycles) -> IDLE with rd_valid.
// Writes are a one-stage registered pass-through to the processed memory.
module image_mem_port #(
    parameter int IMG_PIXELS   = img_pkg::IMG_PIXELS,
    parameter int ADDR_W       = img_pkg::ADDR_W,
    parameter int PIX_W        = img_pkg::PIX_W,
    parameter int DATA_W       = img_pkg::DATA_W,
    parameter int READ_LATENCY = img_pkg::READ_LATENCY
) (
    input  logic               clk,
    input  logic               rst_n,
    image_mem_port_if.slave    bus,
    output logic               raw_en,
    output logic [ADDR_W-1:0]  raw_addr,
    input  logic [PIX_W-1:0]   raw_q,
    output logic               proc_we,
    output logic [ADDR_W-1:0]  proc_addr,
    output logic [PIX_W-1:0]   proc_d,
    output logic [ADDR_W-1:0]  rd_ptr,
    output logic [ADDR_W-1:0]  wr_ptr,
    output logic               frame_done,
    output img_pkg::dbg_t      dbg
);
    import img_pkg::*;

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY);

    rd_state_e         state_q, state_d;
    logic [1:0]        lat_q, lat_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              raw_en_q, raw_en_d;
    logic [ADDR_W-1:0] raw_addr_q, raw_addr_d;
    logic              proc_we_q, proc_we_d;
    logic [ADDR_W-1:0] proc_addr_q, proc_addr_d;
    logic [PIX_W-1:0]  proc_d_q, proc_d_d;
    logic              frame_done_q, frame_done_d;

    logic              rd_accept;
    logic              rd_at_last;
    logic              wr_at_last;
    logic [ADDR_W-1:0] rd_ptr_cnt;
    logic [ADDR_W-1:0] wr_ptr_cnt;
    logic              unused_wr_bits;

    wrap_counter #(.IMG_PIXELS(IMG_PIXELS), .ADDR_W(ADDR_W)) u_rd_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.ptr_clr),
        .inc     (rd_accept),
        .value   (rd_ptr_cnt),
        .at_last (rd_at_last)
    );

    wrap_counter #(.IMG_PIXELS(IMG_PIXELS), .ADDR_W(ADDR_W)) u_wr_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.ptr_clr),
        .inc     (bus.wr_req),
        .value   (wr_ptr_cnt),
        .at_last (wr_at_last)
    );

    // Read channel FSM.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        rd_accept  = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        raw_en_d   = 1'b0;
        raw_addr_d = raw_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.rd_req) begin
                    rd_accept  = 1'b1;
                    raw_en_d   = 1'b1;
                    raw_addr_d = bus.ptr_clr ? '0 : rd_ptr_cnt;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - 2'd1;
                // raw_q is valid in the last WAIT cycle: raw_en was high
                // READ_LATENCY cycles earlier, in ISSUE.
                if (lat_q == 2'd1) begin
                    rd_data_d  = DATA_W'(raw_q);
                    rd_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write channel: one cycle from request to the memory strobe.
    always_comb begin
        proc_we_d    = bus.wr_req;
        proc_addr_d  = proc_addr_q;
        proc_d_d     = proc_d_q;
        // The last pixel is written only if the pointer is not being cleared.
        frame_done_d = bus.wr_req && wr_at_last && !bus.ptr_clr;
        if (bus.wr_req) begin
            proc_addr_d = bus.ptr_clr ? '0 : wr_ptr_cnt;
            proc_d_d    = bus.wr_data[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            raw_en_q     <= 1'b0;
            raw_addr_q   <= '0;
            proc_we_q    <= 1'b0;
            proc_addr_q  <= '0;
            proc_d_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            raw_en_q     <= raw_en_d;
            raw_addr_q   <= raw_addr_d;
            proc_we_q    <= proc_we_d;
            proc_addr_q  <= proc_addr_d;
            proc_d_q     <= proc_d_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Only the low pixel bits of wr_data are stored.
    assign unused_wr_bits = ^bus.wr_data[DATA_W-1:PIX_W];

    assign bus.rd_ready = (state_q == IDLE);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign raw_en       = raw_en_q;
    assign raw_addr     = raw_addr_q;
    assign proc_we      = proc_we_q;
    assign proc_addr    = proc_addr_q;
    assign proc_d       = proc_d_q;
    assign frame_done   = frame_done_q;
    assign rd_ptr       = rd_ptr_cnt;
    assign wr_ptr       = wr_ptr_cnt;

    always_comb begin
        dbg.rd_state       = state_q;
        dbg.lat_cnt        = lat_q;
        dbg.rd_ptr_at_last = rd_at_last;
        dbg.wr_ptr_at_last = wr_at_last;
    end
endmodule
